// File: rtl/adder_share_arbiter_if.sv
// ============================================================================
// Module   : adder_share_arbiter_if
// Brief    : Request/response channel bundle between requesters and the
//            shared-adder arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adder_share_arbiter_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_in1;
    logic [NUM_REQ*WIDTH-1:0] req_in2;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [ID_W-1:0]          resp_id;
    logic [WIDTH:0]           resp_sum;

    modport master (
        output req_valid, req_in1, req_in2, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_sum
    );

    modport slave (
        input  req_valid, req_in1, req_in2, resp_ready,
        output req_ready, resp_valid, resp_id, resp_sum
    );
endinterface

`default_nettype wire

// File: rtl/adder_share_arbiter.sv
// ============================================================================
// Module   : adder_share_arbiter
// Brief    : Round-robin sharing of one registered adder among NUM_REQ
//            requesters, one operation in flight, valid/ready response.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_share_arbiter #(
    parameter int WIDTH       = 8,
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    adder_share_arbiter_if.slave  bus,
    output logic [WIDTH-1:0]      add_in1,
    output logic [WIDTH-1:0]      add_in2,
    input  logic [WIDTH:0]        add_out,
    output logic                  busy
);
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int C_CNT_W = (ADD_LATENCY > 0) ? $clog2(ADD_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]    r_add_in1;
    logic [WIDTH-1:0]    r_add_in2;
    logic                r_resp_valid;
    logic [ID_W-1:0]     r_resp_id;
    logic [WIDTH:0]      r_resp_sum;
    logic                r_busy;

    logic [NUM_REQ-1:0]  w_rot;
    logic                w_found;
    logic [ID_W-1:0]     w_offset;
    logic [ID_W:0]       w_raw;
    logic [ID_W-1:0]     w_winner;
    logic [ID_W-1:0]     w_rr_next;
    logic [NUM_REQ-1:0]  w_grant;
    logic [WIDTH-1:0]    w_op1;
    logic [WIDTH-1:0]    w_op2;

    // Rotate requests so bit 0 is the requester at rr_ptr; the first set bit
    // is then the round-robin winner's distance from the pointer.
    assign w_rot = NUM_REQ'({bus.req_valid, bus.req_valid} >> r_rr_ptr);

    always_comb begin
        w_found  = 1'b0;
        w_offset = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found  = 1'b1;
                w_offset = ID_W'(k);
            end
        end
    end

    assign w_raw     = {1'b0, r_rr_ptr} + {1'b0, w_offset};
    assign w_winner  = (w_raw >= (ID_W+1)'(NUM_REQ)) ?
                       ID_W'(w_raw - (ID_W+1)'(NUM_REQ)) : w_raw[ID_W-1:0];
    assign w_rr_next = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

    always_comb begin
        w_grant = '0;
        w_op1   = '0;
        w_op2   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst && (r_state == S_IDLE) && w_found && (w_winner == ID_W'(i))) begin
                w_grant[i] = 1'b1;
                w_op1      = bus.req_in1[i*WIDTH +: WIDTH];
                w_op2      = bus.req_in2[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_cnt        <= '0;
            r_add_in1    <= '0;
            r_add_in2    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_sum   <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_add_in1 <= w_op1;
                        r_add_in2 <= w_op2;
                        r_resp_id <= w_winner;
                        r_rr_ptr  <= w_rr_next;
                        r_cnt     <= C_CNT_W'(ADD_LATENCY);
                        r_busy    <= 1'b1;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Operands stay put so the adder output settles on them.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_resp_sum   <= add_out;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = w_grant;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_sum   = r_resp_sum;
    assign add_in1        = r_add_in1;
    assign add_in2        = r_add_in2;
    assign busy           = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
// ============================================================================
// Module   : tb_adder_share_arbiter
// Brief    : Directed scoreboard bench for adder_share_arbiter (latency 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_share_arbiter;
    localparam int W = 8;
    localparam int N = 4;

    typedef struct packed {
        logic [1:0] id;
        logic [8:0] sum;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_share_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus1 ();
    adder_share_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus3 ();

    logic [W-1:0] a1_in1, a1_in2, a3_in1, a3_in2;
    logic [W:0]   a1_out, a3_out;
    logic         busy1, busy3;

    adder_share_arbiter #(.WIDTH(W), .NUM_REQ(N), .ADD_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .bus(bus1),
        .add_in1(a1_in1), .add_in2(a1_in2), .add_out(a1_out), .busy(busy1)
    );

    adder_share_arbiter #(.WIDTH(W), .NUM_REQ(N), .ADD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3),
        .add_in1(a3_in1), .add_in2(a3_in2), .add_out(a3_out), .busy(busy3)
    );

    // Shared-adder models: one and three register stages.
    logic [W:0] p1;
    logic [W:0] p3 [3];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p1    <= '0;
            p3[0] <= '0;
            p3[1] <= '0;
            p3[2] <= '0;
        end else begin
            p1    <= {1'b0, a1_in1} + {1'b0, a1_in2};
            p3[0] <= {1'b0, a3_in1} + {1'b0, a3_in2};
            p3[1] <= p3[0];
            p3[2] <= p3[1];
        end
    end
    assign a1_out = p1;
    assign a3_out = p3[2];

    exp_t exp_q [$];
    exp_t exp3_q [$];

    logic [W-1:0] op_a [N][16];
    logic [W-1:0] op_b [N][16];
    int           op_n [N];
    int           op_k [N];

    logic [N-1:0] gnt_s  = '0;
    logic [N-1:0] gnt3_s = '0;
    int  vec_n = 0;
    int  err_n = 0;
    int  cyc   = 0;
    bit  done  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus helpers (main process only) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (gnt_s[i]) begin
                op_k[i]++;
                if (op_k[i] < op_n[i]) begin
                    bus1.req_in1[i*W +: W] = op_a[i][op_k[i]];
                    bus1.req_in2[i*W +: W] = op_b[i][op_k[i]];
                end else begin
                    bus1.req_valid[i] = 1'b0;
                end
            end
            if (gnt3_s[i]) bus3.req_valid[i] = 1'b0;
        end
    endtask

    task automatic issue(input int id, input int a, input int b);
        op_a[id][op_n[id]] = W'(a);
        op_b[id][op_n[id]] = W'(b);
        if (op_k[id] == op_n[id]) begin
            bus1.req_in1[id*W +: W] = W'(a);
            bus1.req_in2[id*W +: W] = W'(b);
            bus1.req_valid[id]      = 1'b1;
        end
        op_n[id]++;
    endtask

    task automatic expect_resp(input int id, input int sum);
        exp_q.push_back('{id: 2'(id), sum: 9'(sum)});
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && (exp_q.size() != 0 || busy1); n++) tick();
        tick();
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic chk(input string name, input int act, input int req);
        vec_n++;
        if (act != req) begin
            err_n++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    bit m_busy  = 1'b0;
    bit rv_prev = 1'b0;
    bit rv3_prev = 1'b0;
    int acc  = 0;
    int acc3 = 0;
    int wd   = 0;

    always @(negedge clk) begin
        if (done) begin
            chk("queue_drained", exp_q.size(), 0);
            chk("queue3_drained", exp3_q.size(), 0);
            $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
            $finish;
        end else if (rst) begin
            chk("rst_req_ready", int'(bus1.req_ready), 0);
            chk("rst_resp_valid", int'(bus1.resp_valid), 0);
            chk("rst_resp_sum", int'(bus1.resp_sum), 0);
            chk("rst_resp_id", int'(bus1.resp_id), 0);
            chk("rst_busy", int'(busy1), 0);
            chk("rst_add_in1", int'(a1_in1), 0);
            chk("rst_add_in2", int'(a1_in2), 0);
            chk("rst_busy3", int'(busy3), 0);
            exp_q.delete();
            exp3_q.delete();
            m_busy   = 1'b0;
            rv_prev  = 1'b0;
            rv3_prev = 1'b0;
            gnt_s    = '0;
            gnt3_s   = '0;
            wd       = 0;
        end else begin
            gnt_s = bus1.req_ready;
            chk("grant_onehot", int'($onehot0(gnt_s) && ((gnt_s & ~bus1.req_valid) == '0)), 1);
            chk("busy", int'(busy1), int'(m_busy));
            if (m_busy) chk("grant_while_busy", int'(gnt_s), 0);
            else if (bus1.req_valid != '0) chk("grant_missing", int'(gnt_s != '0), 1);
            if (bus1.resp_valid && !rv_prev) chk("latency", cyc, acc + 2);
            if (bus1.resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    chk("resp_id", int'(bus1.resp_id), int'(exp_q[0].id));
                    chk("resp_sum", int'(bus1.resp_sum), int'(exp_q[0].sum));
                    if (bus1.resp_ready) void'(exp_q.pop_front());
                end
                if (bus1.resp_ready) begin
                    m_busy = 1'b0;
                    wd     = 0;
                end
            end
            rv_prev = bus1.resp_valid;
            if (gnt_s != '0) begin
                acc    = cyc + 1;
                m_busy = 1'b1;
            end
            if (exp_q.size() != 0) wd++;
            else wd = 0;
            if (wd > 60) begin
                chk("response_timeout", 1, 0);
                void'(exp_q.pop_front());
                wd = 0;
            end

            gnt3_s = bus3.req_ready;
            if (bus3.resp_valid && !rv3_prev) chk("latency3", cyc, acc3 + 4);
            if (bus3.resp_valid && bus3.resp_ready) begin
                if (exp3_q.size() == 0) begin
                    chk("unexpected_resp3", 1, 0);
                end else begin
                    chk("resp3_id", int'(bus3.resp_id), int'(exp3_q[0].id));
                    chk("resp3_sum", int'(bus3.resp_sum), int'(exp3_q[0].sum));
                    void'(exp3_q.pop_front());
                end
            end
            rv3_prev = bus3.resp_valid;
            if (gnt3_s != '0) acc3 = cyc + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < N; i++) begin
            op_n[i] = 0;
            op_k[i] = 0;
        end
        bus1.req_valid = '0; bus1.req_in1 = '0; bus1.req_in2 = '0; bus1.resp_ready = 1'b1;
        bus3.req_valid = '0; bus3.req_in1 = '0; bus3.req_in2 = '0; bus3.resp_ready = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Latency-3 build: single request, 17+25.
        bus3.req_in1[0 +: W] = 8'd17;
        bus3.req_in2[0 +: W] = 8'd25;
        bus3.req_valid[0]    = 1'b1;
        exp3_q.push_back('{id: 2'd0, sum: 9'd42});
        for (int n = 0; n < 50 && exp3_q.size() != 0; n++) tick();
        tick();

        // All four requesters busy from reset: round robin 0,1,2,3,0,1,2,3.
        issue(0, 1, 2);     issue(1, 3, 4);    issue(2, 5, 6);    issue(3, 7, 8);
        issue(0, 10, 20);   issue(1, 30, 40);  issue(2, 50, 60);  issue(3, 255, 1);
        expect_resp(0, 3);  expect_resp(1, 7);  expect_resp(2, 11);  expect_resp(3, 15);
        expect_resp(0, 30); expect_resp(1, 70); expect_resp(2, 110); expect_resp(3, 256);
        drain();

        // Single request.
        issue(2, 200, 100); expect_resp(2, 300);
        drain();

        // Operand extremes.
        issue(1, 255, 255); expect_resp(1, 510);
        drain();
        issue(0, 0, 0);     expect_resp(0, 0);
        drain();

        // Pointer wrap: grant 3, then 1 beats 3.
        issue(3, 9, 9);     expect_resp(3, 18);
        drain();
        issue(1, 11, 12);   issue(3, 13, 14);
        expect_resp(1, 23); expect_resp(3, 27);
        drain();

        // Backpressure held for 10 cycles with a second requester waiting.
        bus1.resp_ready = 1'b0;
        issue(0, 100, 27);  issue(2, 3, 4);
        expect_resp(0, 127); expect_resp(2, 7);
        for (int n = 0; n < 20 && !bus1.resp_valid; n++) tick();
        repeat (10) tick();
        bus1.resp_ready = 1'b1;
        drain();

        // Reset in the middle of WAIT; lowest valid index wins afterwards.
        issue(2, 20, 22);   expect_resp(2, 42);
        for (int n = 0; n < 20 && !busy1; n++) tick();
        rst = 1'b1;
        tick();
        issue(1, 1, 2);     issue(3, 3, 4);
        tick();
        rst = 1'b0;
        expect_resp(1, 3);  expect_resp(3, 7);
        drain();

        done = 1'b1;
    end

endmodule

`default_nettype wire
